// File: rtl/mem_arbiter.sv
// Two-cache to single-port RAM arbiter: grants one word at a time and handles RAM latency and errors.
// Optional define MEM_ARB_ROUND_ROBIN_EN selects round-robin arbitration instead of fixed dcache priority.
module mem_arbiter #(
    parameter int ERRW = 8
) (
    input  logic            CLK,
    input  logic            nRST,
    input  logic            iREN,
    input  logic [31:0]     iaddr,
    input  logic            dREN,
    input  logic            dWEN,
    input  logic [31:0]     daddr,
    input  logic [31:0]     dstore,
    output logic            iwait,
    output logic [31:0]     iload,
    output logic            dwait,
    output logic [31:0]     dload,
    output logic            ramREN,
    output logic            ramWEN,
    output logic [31:0]     ramaddr,
    output logic [31:0]     ramstore,
    input  logic [31:0]     ramload,
    input  logic [1:0]      ramstate,
    output logic [ERRW-1:0] err_count
);

    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DSERV = 2'd1,
        ISERV = 2'd2
    } state_t;

    state_t          state_reg;
    state_t          state_next;
    logic [ERRW-1:0] err_count_reg;
    logic            err_hit;
    logic            d_req;
    logic            i_req;
    logic            pick_d;
    logic            pick_i;
    logic            served_req;

    assign d_req = dREN | dWEN;
    assign i_req = iREN;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic last_d_reg;
    logic last_d_next;

    // On a tie the cache that was not granted last wins.
    assign pick_d = d_req & (~i_req | ~last_d_reg);

    always_comb begin
        last_d_next = last_d_reg;
        if (state_reg == IDLE) begin
            if (pick_d) begin
                last_d_next = 1'b1;
            end else if (pick_i) begin
                last_d_next = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            last_d_reg <= 1'b0;
        end else begin
            last_d_reg <= last_d_next;
        end
    end
`else
    assign pick_d = d_req;
`endif

    assign pick_i     = i_req & ~pick_d;
    assign served_req = (state_reg == DSERV) ? d_req : i_req;

    // An abandoned request leaves without a completion and without counting an error.
    always_comb begin
        state_next = state_reg;
        err_hit    = 1'b0;
        unique case (state_reg)
            IDLE: begin
                if (pick_d) begin
                    state_next = DSERV;
                end else if (pick_i) begin
                    state_next = ISERV;
                end
            end
            DSERV, ISERV: begin
                if (!served_req) begin
                    state_next = IDLE;
                end else if (ramstate == RAM_ACCESS) begin
                    state_next = IDLE;
                end else if (ramstate == RAM_ERROR) begin
                    state_next = IDLE;
                    err_hit    = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_reg     <= IDLE;
            err_count_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (err_hit && (err_count_reg != {ERRW{1'b1}})) begin
                err_count_reg <= err_count_reg + ERRW'(1);
            end
        end
    end

    assign err_count = err_count_reg;

    // Outputs are purely combinational so a zero-latency RAM completes in the first granted cycle.
    always_comb begin
        iwait    = 1'b1;
        dwait    = 1'b1;
        iload    = '0;
        dload    = '0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        unique case (state_reg)
            DSERV: begin
                ramaddr  = daddr;
                ramstore = dstore;
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                if (d_req && (ramstate == RAM_ACCESS)) begin
                    dwait = 1'b0;
                    dload = ramload;
                end
            end
            ISERV: begin
                ramaddr = iaddr;
                ramREN  = iREN;
                if (i_req && (ramstate == RAM_ACCESS)) begin
                    iwait = 1'b0;
                    iload = ramload;
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized run against a cycle-level reference model.
`timescale 1ns/1ps
module tb_mem_arbiter;

    localparam int ERRW = 8;
    localparam logic [1:0] ST_FREE   = 2'd0;
    localparam logic [1:0] ST_BUSY   = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;
    localparam logic [1:0] ST_ERROR  = 2'd3;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic            CLK = 1'b0;
    logic            nRST = 1'b0;
    logic            iREN, dREN, dWEN;
    logic [31:0]     iaddr, daddr, dstore, ramload;
    logic [1:0]      ramstate;
    logic            iwait, dwait, ramREN, ramWEN;
    logic [31:0]     iload, dload, ramaddr, ramstore;
    logic [ERRW-1:0] err_count;

    int n_checks = 0;
    int n_fail   = 0;

    mem_arbiter #(.ERRW(ERRW)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .iwait(iwait), .iload(iload), .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .err_count(err_count)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        iREN = 0; iaddr = 0; dREN = 0; dWEN = 0; daddr = 0; dstore = 0;
        ramload = 0; ramstate = ST_FREE;
    endtask

    task automatic do_reset();
        idle_inputs();
        @(negedge CLK); nRST = 0;
        tick(); tick();
        @(negedge CLK); nRST = 1;
        tick();
    endtask

    task automatic test_reset();
        idle_inputs();
        iREN = 1; dREN = 1; dWEN = 1; daddr = 32'h1234; dstore = 32'h5678;
        iaddr = 32'h9abc; ramstate = ST_ACCESS; ramload = 32'hFFFF_FFFF;
        nRST = 0;
        #3;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if ({iwait, dwait, ramREN, ramWEN} !== 4'b1100) begin
                n_fail++; $display("FAIL reset_ctl[%0d]: got %b want 1100", k, {iwait, dwait, ramREN, ramWEN});
            end
            n_checks++;
            if ({ramaddr, ramstore, iload, dload} !== 128'd0) begin
                n_fail++; $display("FAIL reset_data[%0d]: got %h want 0", k, {ramaddr, ramstore, iload, dload});
            end
            n_checks++;
            if (err_count !== 8'd0) begin
                n_fail++; $display("FAIL reset_errcnt[%0d]: got %0d want 0", k, err_count);
            end
            tick(); #2;
        end
        idle_inputs();
        @(negedge CLK); nRST = 1;
        tick();
    endtask

    task automatic test_dread_latency();
        logic [1:0]  seq [4];
        logic [1:0]  e_ren;
        logic [31:0] e_addr, e_load;
        logic        e_wait;
        seq[0] = ST_FREE; seq[1] = ST_BUSY; seq[2] = ST_BUSY; seq[3] = ST_ACCESS;
        for (int c = 0; c < 4; c++) begin
            dREN = 1; daddr = 32'h40; ramstate = seq[c];
            ramload = (c == 3) ? 32'hDEADBEEF : (32'h0BAD_0000 + 32'(c));
            #2;
            e_ren  = (c >= 1) ? 2'b10 : 2'b00;
            e_addr = (c >= 1) ? 32'h40 : 32'h0;
            e_wait = (c != 3);
            e_load = (c == 3) ? 32'hDEADBEEF : 32'h0;
            n_checks++;
            if ({ramREN, ramWEN, ramaddr, dwait, dload, iwait} !== {e_ren, e_addr, e_wait, e_load, 1'b1}) begin
                n_fail++;
                $display("FAIL dread_c%0d: got ren=%b wen=%b addr=%h dwait=%b dload=%h iwait=%b want ren=%b addr=%h dwait=%b dload=%h iwait=1",
                         c, ramREN, ramWEN, ramaddr, dwait, dload, iwait, e_ren[1], e_addr, e_wait, e_load);
            end
            if (!dwait) $display("[%0t] dcache read 0x40 -> %h", $time, dload);
            tick();
        end
        idle_inputs();
        #2;
        n_checks++;
        if ({ramREN, dwait, dload} !== {1'b0, 1'b1, 32'h0}) begin
            n_fail++; $display("FAIL dread_after: got ren=%b dwait=%b dload=%h want 0 1 0", ramREN, dwait, dload);
        end
        tick();
    endtask

    task automatic test_dwrite_back_to_back();
        logic [31:0] data [2];
        int          pulses[$];
        int          w = 0;
        logic        e_wen;
        logic [31:0] e_addr, e_store;
        data[0] = $urandom; data[1] = $urandom;
        for (int c = 0; c < 6; c++) begin
            dWEN = (w < 2); daddr = 32'h100 + 32'(4 * (w % 2)); dstore = data[w % 2];
            ramstate = ST_ACCESS; ramload = $urandom;
            #2;
            e_wen   = (c == 1) || (c == 3);
            e_addr  = e_wen ? (32'h100 + 32'(4 * ((c - 1) / 2))) : 32'h0;
            e_store = e_wen ? data[(c - 1) / 2] : 32'h0;
            n_checks++;
            if ({ramWEN, ramREN, ramaddr, ramstore, dwait} !== {e_wen, 1'b0, e_addr, e_store, ~e_wen}) begin
                n_fail++;
                $display("FAIL dwrite_c%0d: got wen=%b ren=%b addr=%h store=%h dwait=%b want wen=%b ren=0 addr=%h store=%h dwait=%b",
                         c, ramWEN, ramREN, ramaddr, ramstore, dwait, e_wen, e_addr, e_store, ~e_wen);
            end
            if (!dwait) begin
                $display("[%0t] dcache write %h <- %h", $time, ramaddr, ramstore);
                pulses.push_back(c);
                w++;
            end
            tick();
        end
        idle_inputs();
        n_checks++;
        if (pulses.size() != 2 || (pulses[1] - pulses[0]) != 2) begin
            n_fail++; $display("FAIL dwrite_spacing: got %0d pulses (gap %0d) want 2 pulses gap 2",
                               pulses.size(), (pulses.size() == 2) ? pulses[1] - pulses[0] : -1);
        end
    endtask

    task automatic test_priority();
        int order[$];
        int d_left = 2;
        bit i_left = 1;
        int e0, e1, e2;
        for (int c = 0; c < 12 && (d_left > 0 || i_left); c++) begin
            dREN = (d_left > 0); daddr = 32'h200 + 32'(4 * (2 - d_left));
            iREN = i_left; iaddr = 32'h300;
            ramstate = ST_ACCESS; ramload = {16'hA5A5, 16'(c)};
            #2;
            n_checks++;
            if (!iwait && !dwait) begin
                n_fail++; $display("FAIL prio_both_low_c%0d: got iwait=0 dwait=0 want at most one low", c);
            end
            if (!dwait) begin order.push_back(1); d_left--; $display("[%0t] grant order: dcache", $time); end
            if (!iwait) begin order.push_back(2); i_left = 0; $display("[%0t] grant order: icache", $time); end
            tick();
        end
        idle_inputs();
        e0 = 1; e1 = RR ? 2 : 1; e2 = RR ? 1 : 2;
        n_checks++;
        if (order.size() != 3 || order[0] != e0 || order[1] != e1 || order[2] != e2) begin
            n_fail++;
            $display("FAIL prio_order: got %0d entries [%0d %0d %0d] want [%0d %0d %0d] (1=d 2=i)", order.size(),
                     (order.size() > 0) ? order[0] : 0, (order.size() > 1) ? order[1] : 0,
                     (order.size() > 2) ? order[2] : 0, e0, e1, e2);
        end
    endtask

    task automatic test_error_iserv();
        logic [31:0] a, v;
        do_reset();
        a = $urandom; v = $urandom;
        iREN = 1; iaddr = a; ramstate = ST_FREE;
        tick();
        ramstate = ST_ERROR; #2;
        n_checks++;
        if ({ramREN, ramaddr, iwait, iload} !== {1'b1, a, 1'b1, 32'h0}) begin
            n_fail++; $display("FAIL err_iserv: got ren=%b addr=%h iwait=%b iload=%h want 1 %h 1 0", ramREN, ramaddr, iwait, iload, a);
        end
        tick();
        ramstate = ST_FREE; #2;
        n_checks++;
        if ({ramREN, iwait, err_count} !== {1'b0, 1'b1, 8'd1}) begin
            n_fail++; $display("FAIL err_retry_idle: got ren=%b iwait=%b err_count=%0d want 0 1 1", ramREN, iwait, err_count);
        end
        tick();
        ramstate = ST_ACCESS; ramload = v; #2;
        n_checks++;
        if ({ramREN, iwait, iload} !== {1'b1, 1'b0, v}) begin
            n_fail++; $display("FAIL err_retry_done: got ren=%b iwait=%b iload=%h want 1 0 %h", ramREN, iwait, iload, v);
        end
        tick();
        do_reset();
        iREN = 1; iaddr = a; ramstate = ST_ERROR;
        for (int k = 0; k < 255; k++) begin tick(); tick(); end
        n_checks++;
        if (err_count !== 8'd255) begin
            n_fail++; $display("FAIL err_count_255: got %0d want 255", err_count);
        end
        tick(); tick();
        n_checks++;
        if (err_count !== 8'd255) begin
            n_fail++; $display("FAIL err_count_saturate: got %0d want 255", err_count);
        end
        $display("[%0t] 256 forced icache errors, err_count=%0d", $time, err_count);
        idle_inputs();
        tick();
    endtask

    task automatic test_rw_abandon();
        logic [31:0] a, s;
        a = $urandom; s = $urandom;
        dREN = 1; dWEN = 1; daddr = a; dstore = s; ramstate = ST_BUSY;
        tick();
        #2;
        n_checks++;
        if ({ramWEN, ramREN, ramaddr, ramstore, dwait} !== {1'b1, 1'b0, a, s, 1'b1}) begin
            n_fail++; $display("FAIL rw_conflict: got wen=%b ren=%b addr=%h store=%h dwait=%b want 1 0 %h %h 1",
                               ramWEN, ramREN, ramaddr, ramstore, dwait, a, s);
        end
        tick();
        dREN = 0; dWEN = 0; #2;
        n_checks++;
        if ({ramWEN, ramREN, dwait} !== 3'b001) begin
            n_fail++; $display("FAIL rw_drop: got wen=%b ren=%b dwait=%b want 0 0 1", ramWEN, ramREN, dwait);
        end
        tick();
        ramstate = ST_ACCESS; #2;
        n_checks++;
        if ({ramaddr, dwait} !== {32'h0, 1'b1}) begin
            n_fail++; $display("FAIL rw_back_idle: got addr=%h dwait=%b want 0 1", ramaddr, dwait);
        end
        dREN = 1; ramstate = ST_BUSY;
        tick(); tick();
        dREN = 0; ramstate = ST_ACCESS; #2;
        n_checks++;
        if ({ramREN, dwait, dload} !== {1'b0, 1'b1, 32'h0}) begin
            n_fail++; $display("FAIL rd_abandon_no_pulse: got ren=%b dwait=%b dload=%h want 0 1 0", ramREN, dwait, dload);
        end
        tick();
        dREN = 1; #2;
        n_checks++;
        if (ramREN !== 1'b0) begin
            n_fail++; $display("FAIL rd_abandon_idle: got ren=%b want 0", ramREN);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_reset_mid_access();
        dREN = 1; dWEN = 0; daddr = 32'h80; ramstate = ST_BUSY;
        tick(); #2;
        n_checks++;
        if ({ramREN, ramaddr} !== {1'b1, 32'h80}) begin
            n_fail++; $display("FAIL midrst_pre: got ren=%b addr=%h want 1 00000080", ramREN, ramaddr);
        end
        #1 nRST = 0;
        #1;
        n_checks++;
        if ({ramREN, ramWEN, iwait, dwait, ramaddr, ramstore, iload, dload, err_count} !== {4'b0011, 128'd0, 8'd0}) begin
            n_fail++; $display("FAIL midrst_async: got ren=%b wen=%b iwait=%b dwait=%b addr=%h err=%0d want 0 0 1 1 0 0",
                               ramREN, ramWEN, iwait, dwait, ramaddr, err_count);
        end
        tick();
        @(negedge CLK); nRST = 1; #1;
        n_checks++;
        if (ramREN !== 1'b0) begin
            n_fail++; $display("FAIL midrst_idle: got ren=%b want 0", ramREN);
        end
        tick();
        n_checks++;
        if ({ramREN, ramaddr} !== {1'b1, 32'h80}) begin
            n_fail++; $display("FAIL midrst_restart: got ren=%b addr=%h want 1 00000080", ramREN, ramaddr);
        end
        idle_inputs();
        tick(); tick();
    endtask

    task automatic test_random();
        bit          d_act, i_act, abandon, last_d;
        int          d_kind, owner, exp_err, r, n_d, n_i;
        logic [31:0] d_a, d_s, i_a;
        logic [139:0] exp_v, got_v;
        logic        e_iw, e_dw, e_ren, e_wen;
        logic [31:0] e_addr, e_st, e_il, e_dl;
        d_act = 0; i_act = 0; last_d = 0; owner = 0; exp_err = 0; n_d = 0; n_i = 0;
        d_kind = 0; d_a = 0; d_s = 0; i_a = 0;
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            abandon = 0;
            if (!d_act) begin
                if ($urandom_range(0, 1) == 1) begin
                    d_act = 1; d_kind = $urandom_range(0, 2); d_a = $urandom; d_s = $urandom;
                end
            end else if ($urandom_range(0, 15) == 0) begin
                d_act = 0; abandon = 1;
            end
            if (!i_act) begin
                if ($urandom_range(0, 1) == 1) begin i_act = 1; i_a = $urandom; end
            end else if ($urandom_range(0, 15) == 0) begin
                i_act = 0; abandon = 1;
            end
            dREN = d_act && (d_kind != 1); dWEN = d_act && (d_kind != 0);
            daddr = d_a; dstore = d_s; iREN = i_act; iaddr = i_a;
            ramload = $urandom;
            r = $urandom_range(0, 7);
            ramstate = (r < 2) ? ST_FREE : (r < 4) ? ST_BUSY : (r < 7) ? ST_ACCESS : ST_ERROR;
            if (abandon) ramstate = ST_BUSY;
            #2;
            // Expected behaviour from whoever currently owns the RAM.
            e_iw = 1; e_dw = 1; e_ren = 0; e_wen = 0; e_addr = 0; e_st = 0; e_il = 0; e_dl = 0;
            if (owner == 1) begin
                e_addr = daddr; e_st = dstore; e_wen = dWEN; e_ren = dREN && !dWEN;
                if ((dREN || dWEN) && ramstate == ST_ACCESS) begin e_dw = 0; e_dl = ramload; end
            end else if (owner == 2) begin
                e_addr = iaddr; e_ren = iREN;
                if (iREN && ramstate == ST_ACCESS) begin e_iw = 0; e_il = ramload; end
            end
            exp_v = {e_iw, e_dw, e_ren, e_wen, e_addr, e_st, e_il, e_dl, 8'(exp_err)};
            got_v = {iwait, dwait, ramREN, ramWEN, ramaddr, ramstore, iload, dload, err_count};
            n_checks++;
            if (got_v !== exp_v) begin
                n_fail++; $display("FAIL random_c%0d: got %h want %h (owner %0d)", cyc, got_v, exp_v, owner);
            end
            case (owner)
                0: begin
                    if ((dREN || dWEN) && (!RR || !iREN || !last_d)) begin owner = 1; last_d = 1; end
                    else if (iREN) begin owner = 2; last_d = 0; end
                end
                1: begin
                    if (!(dREN || dWEN)) owner = 0;
                    else if (ramstate == ST_ACCESS) begin owner = 0; d_act = 0; n_d++; end
                    else if (ramstate == ST_ERROR) begin owner = 0; if (exp_err < 255) exp_err++; end
                end
                default: begin
                    if (!iREN) owner = 0;
                    else if (ramstate == ST_ACCESS) begin owner = 0; i_act = 0; n_i++; end
                    else if (ramstate == ST_ERROR) begin owner = 0; if (exp_err < 255) exp_err++; end
                end
            endcase
            tick();
        end
        idle_inputs();
        $display("[%0t] random run: %0d dcache words, %0d icache words, %0d errors", $time, n_d, n_i, exp_err);
        tick();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_dread_latency();
        test_dwrite_back_to_back();
        test_priority();
        test_error_iserv();
        test_rw_abandon();
        test_reset_mid_access();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Sequential memory-side responder for the `caches_if` protocol. It accepts word requests from the icache and the dcache, grants one at a time, and drives the single-port RAM. It returns each `iwait`/`dwait` low for exactly one cycle when the RAM reports `ACCESS`. It sits between both caches and the RAM model and owns all arbitration and RAM-latency handling.

## Interface
- `ERRW`, default 8: width of the saturating RAM-error counter.
- `CLK`  in  1  system clock, rising edge.
- `nRST`  in  1  reset, asynchronous, active-low.
- `iREN`  in  1  icache read request.
- `iaddr`  in  32  icache word address.
- `dREN`  in  1  dcache read request.
- `dWEN`  in  1  dcache write request.
- `daddr`  in  32  dcache word address.
- `dstore`  in  32  dcache write data.
- `iwait`  out  1  icache stall; low for one cycle when the icache access completes.
- `iload`  out  32  icache read data; valid while `iwait`=0.
- `dwait`  out  1  dcache stall; low for one cycle when the dcache access completes.
- `dload`  out  32  dcache read data; valid while `dwait`=0.
- `ramREN`  out  1  RAM read enable.
- `ramWEN`  out  1  RAM write enable.
- `ramaddr`  out  32  RAM address.
- `ramstore`  out  32  RAM write data.
- `ramload`  in  32  RAM read data.
- `ramstate`  in  2  RAM status: FREE=0, BUSY=1, ACCESS=2, ERROR=3.
- `err_count`  out  ERRW  number of ERROR responses seen; saturates at all-ones.

## Operation
- The FSM has three states: IDLE, DSERV and ISERV. The grant is registered and the FSM resets to IDLE.
- **IDLE**
  - All RAM enables are 0. `iwait`=`dwait`=1.
  - If `dREN|dWEN`, the next state is DSERV.
  - Otherwise, if `iREN`, the next state is ISERV.
- **DSERV**
  - `ramaddr`=`daddr` and `ramstore`=`dstore`.
  - If `dWEN`=1, drive `ramWEN`=1 and `ramREN`=0, even when `dREN` is also 1 (write wins).
  - Otherwise, drive `ramREN`=`dREN`.
- **DSERV response handling**
  - On `ramstate`=ACCESS: `dwait`=0 and `dload`=`ramload`; the next state is IDLE.
  - On FREE or BUSY: hold the state with `dwait`=1.
  - On ERROR: `dwait` stays 1, `err_count` increments, and the next state is IDLE, so the request re-arbitrates (retry).
  - If `dREN` and `dWEN` both fall while in DSERV (abandoned request): go to IDLE with no completion pulse.
- **ISERV**
  - Same as DSERV, using `iaddr`, `ramREN`=`iREN`, `iwait` and `iload`. `ramWEN` is always 0.
  - Abandonment is on `iREN` falling.
- `ramstore` is 0 in ISERV and IDLE. `ramaddr` is 0 in IDLE.
- `iload` and `dload` are 0 except in their completion cycle.
- The waits of the non-granted requester are always 1.
- `err_count` saturates at 2^ERRW−1 and does not wrap.

## Timing
- **Reset** (asynchronous, immediate): state=IDLE, `err_count`=0, last-grant=icache.
  - Outputs during reset: `iwait`=`dwait`=1, `ramREN`=`ramWEN`=0, and all data/address outputs 0.
- **Reset mid-access:** the transaction is dropped and the RAM enables drop immediately.
- **Request path:** a request is sampled in IDLE in cycle 0. RAM enables are asserted from cycle 1.
- **Completion:** the earliest completion is cycle 1, if the RAM returns ACCESS in the first granted cycle. In general, completion is the first cycle with ACCESS.
- **Wait pulse:** the wait is low for exactly one cycle per word.
- **Back-to-back words:** a gap of one IDLE cycle follows every completion. A two-word dcache block fill therefore takes at least 4 cycles.
- **Outputs:** all outputs are combinational from the state and current inputs, with no extra register stage. `dload`/`iload` are sampled by the caches on the edge that ends the `wait`=0 cycle.

## Configuration
- `MEM_ARB_ROUND_ROBIN_EN`
  - Defined: in IDLE with both caches requesting, the requester not granted last wins. The last-grant register updates on every grant.
  - Undefined: fixed dcache priority. The icache is served only when the dcache is idle, so starvation is accepted.
- The macro has no effect when only one cache requests.

## Test plan
- **dcache read, RAM latency 2:** `dREN`=1, `daddr`=0x40; RAM returns BUSY, BUSY, ACCESS with `ramload`=0xDEADBEEF → `ramREN`=1 and `ramaddr`=0x40 from cycle 1; `dwait`=0 and `dload`=0xDEADBEEF only in cycle 3.
- **Two-word dcache write-back, zero-latency RAM:** `dWEN`=1 at 0x100 then 0x104 → `ramWEN` with the matching `ramstore`; two single-cycle `dwait` lows, 2 cycles apart.
- **Simultaneous `iREN` and `dREN` twice:**
  - Without the macro: the dcache is served twice before the icache.
  - With `MEM_ARB_ROUND_ROBIN_EN`: the order is d, i, d.
- **ERROR response in ISERV:** the RAM returns ERROR → `iwait` stays 1 and `err_count`=1. The retry then completes on ACCESS; 256 forced errors with ERRW=8 leave `err_count`=255.
- **Simultaneous `dREN` and `dWEN`:** `ramWEN`=1 and `ramREN`=0. Dropping `dWEN`/`dREN` mid-BUSY returns to IDLE with no `dwait` pulse.
- **Reset mid-access:** `nRST` asserted during DSERV → `ramREN`/`ramWEN` fall without waiting for a clock edge, all outputs take their reset values, and the FSM restarts in IDLE.
